icache: RTL

Direct-mapped, one-word-per-line instruction cache between the fetch stage and the instruction port of the byte-serial RAM controller. It answers hits in one cycle and forwards misses to the controller's `inst_*` request/ready interface. It holds every miss request stable until the controller's completion pulse, and it can cancel a pending fetch on a pipeline redirect without violating that interface.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_if.sv | 26 ++
 rtl/icache_array.sv | 46 ++++
 rtl/icache.sv | 103 ++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, state encoding and address helpers for the instruction cache.
package icache_pkg;

   localparam int AddressWidth    = 32;
   localparam int IDWidth         = 32;
   localparam int ICacheIndexBits = 6;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } icache_state_e;

   function automatic logic [AddressWidth-1:0] word_align(input logic [AddressWidth-1:0] addr);
      return {addr[AddressWidth-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-stage and RAM-controller instruction-port signals of the instruction cache.
// The master side is the surrounding pipeline/controller, the slave side is the cache.
interface icache_if;
   import icache_pkg::*;

   logic                    fetch_en_in;
   logic [AddressWidth-1:0] fetch_addr_in;
   logic                    flush_in;
   logic                    fetch_rdy_out;
   logic [IDWidth-1:0]      fetch_inst_out;
   logic                    mem_en_out;
   logic [AddressWidth-1:0] mem_addr_out;
   logic                    mem_rdy_in;
   logic [IDWidth-1:0]      mem_inst_in;

   modport master (
      output fetch_en_in, fetch_addr_in, flush_in, mem_rdy_in, mem_inst_in,
      input  fetch_rdy_out, fetch_inst_out, mem_en_out, mem_addr_out
   );

   modport slave (
      input  fetch_en_in, fetch_addr_in, flush_in, mem_rdy_in, mem_inst_in,
      output fetch_rdy_out, fetch_inst_out, mem_en_out, mem_addr_out
   );

endinterface

// File: rtl/icache_array.sv
// Direct-mapped line storage: combinational read port, synchronous write port,
// valid bits cleared by the synchronous reset.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICacheIndexBits,
   parameter int TAG_BITS   = AddressWidth - ICacheIndexBits - 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [IDWidth-1:0]    rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [IDWidth-1:0]    wr_data
);
   localparam int Lines = 1 << INDEX_BITS;

   logic [Lines-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [Lines];
   logic [IDWidth-1:0]  data_q [Lines];

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache: one-cycle hits, misses
// forwarded to the controller instruction port and held until its completion pulse.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICacheIndexBits
) (
   input  logic    clk_in,
   input  logic    rst_in,
   input  logic    rdy_in,
   icache_if.slave bus
);
   localparam int TagBits = AddressWidth - INDEX_BITS - 2;

   icache_state_e           state;
   logic                    cancel;
   logic [AddressWidth-1:0] miss_addr;
   logic                    fetch_rdy_q;
   logic [IDWidth-1:0]      fetch_inst_q;

   logic [INDEX_BITS-1:0]   lookup_index;
   logic [TagBits-1:0]      lookup_tag;
   logic                    line_valid;
   logic [TagBits-1:0]      line_tag;
   logic [IDWidth-1:0]      line_data;
   logic                    lookup;
   logic                    hit;
   logic                    fill;
   logic                    unused_addr_bits;

   assign lookup_index = bus.fetch_addr_in[INDEX_BITS+1:2];
   assign lookup_tag   = bus.fetch_addr_in[AddressWidth-1:INDEX_BITS+2];
   assign unused_addr_bits = ^{bus.fetch_addr_in[1:0], miss_addr[1:0]};

   // The cycle after a response is skipped so a fetch address that has not yet
   // moved on is not served a second time.
   assign lookup = (state == IDLE) && bus.fetch_en_in && !bus.flush_in && !fetch_rdy_q;
   assign hit    = line_valid && (line_tag == lookup_tag);
   assign fill   = rdy_in && (state == MISS) && bus.mem_rdy_in;

   // The request drops combinationally in the completion cycle, so the controller,
   // already back in its idle stage, does not start a second read.
   assign bus.mem_en_out     = (state == MISS) && !bus.mem_rdy_in;
   assign bus.mem_addr_out   = (state == MISS) ? miss_addr : '0;
   assign bus.fetch_rdy_out  = fetch_rdy_q;
   assign bus.fetch_inst_out = fetch_inst_q;

   icache_array #(
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TagBits)
   ) u_array (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .rd_index(lookup_index),
      .rd_valid(line_valid),
      .rd_tag  (line_tag),
      .rd_data (line_data),
      .wr_en   (fill),
      .wr_index(miss_addr[INDEX_BITS+1:2]),
      .wr_tag  (miss_addr[AddressWidth-1:INDEX_BITS+2]),
      .wr_data (bus.mem_inst_in)
   );

   // A redirect during a miss cannot withdraw the request; it only marks the
   // fill as unwanted so the line is written but no response is produced.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= IDLE;
         cancel       <= 1'b0;
         miss_addr    <= '0;
         fetch_rdy_q  <= 1'b0;
         fetch_inst_q <= '0;
      end else if (rdy_in) begin
         fetch_rdy_q <= 1'b0;
         case (state)
            IDLE: begin
               if (lookup) begin
                  if (hit) begin
                     fetch_inst_q <= line_data;
                     fetch_rdy_q  <= 1'b1;
                  end else begin
                     miss_addr <= word_align(bus.fetch_addr_in);
                     cancel    <= 1'b0;
                     state     <= MISS;
                  end
               end
            end
            MISS: begin
               if (bus.mem_rdy_in) begin
                  state <= IDLE;
                  if (!cancel && !bus.flush_in) begin
                     fetch_inst_q <= bus.mem_inst_in;
                     fetch_rdy_q  <= 1'b1;
                  end
               end else if (bus.flush_in) begin
                  cancel <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
